// File: rtl/dpram_arb_pkg.sv
// Shared types and sizing helpers for the dual-port RAM round-robin arbiter.
package dpram_arb_pkg;

  // Requester index width; never narrower than one bit so NREQ=2 still works.
  function automatic int req_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ISSUE  = 2'd1,
    RD_RETURN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the stored pointer, pointer moves past
// each winner and wraps explicitly at N-1 so non-power-of-2 N is handled.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  localparam int CW = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [CW-1:0]    cand_s;

  // Priority search from the pointer; cand_s never exceeds 2N-2 before the wrap.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + CW'(k);
      if (cand_s >= CW'(N)) begin
        cand_s = cand_s - CW'(N);
      end else begin
        cand_s = cand_s;
      end
      if (advance && !gnt_any && req[cand_s[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_s[IDX_W-1:0];
      end else begin
        gnt_any = gnt_any;
      end
    end
    gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
  end

  always_comb begin
    if (!gnt_any) begin
      ptr_d = ptr_q;
    end else if (gnt_idx == IDX_W'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Shares one dual-port RAM among NREQ clients: independent round-robin write and
// read arbiters, a two-stage read tag pipe and registered, valid-qualified read data.
module dpram_rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NREQ-1:0]           wr_req,
  input  logic [NREQ*ADDR_SIZE-1:0] wr_addr,
  input  logic [NREQ*DATA_SIZE-1:0] wr_data,
  output logic [NREQ-1:0]           wr_gnt,
  input  logic [NREQ-1:0]           rd_req,
  input  logic [NREQ*ADDR_SIZE-1:0] rd_addr,
  output logic [NREQ-1:0]           rd_gnt,
  output logic [NREQ-1:0]           rd_valid,
  output logic [DATA_SIZE-1:0]      rd_data,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_re,
  output logic                      ram_oe,
  output logic [ADDR_SIZE-1:0]      ram_wr_address,
  output logic [ADDR_SIZE-1:0]      ram_rd_address,
  output logic [DATA_SIZE-1:0]      ram_data_in,
  input  logic [DATA_SIZE-1:0]      ram_data_out
);

  localparam int IW = req_idx_w(NREQ);

  logic                 arb_en_s;
  logic [IW-1:0]        wr_win_s;
  logic [IW-1:0]        rd_win_s;
  logic                 wr_any_s;
  logic                 rd_any_s;
  rd_state_e            phase_s;

  rd_state_e            pipe_q,      pipe_d;
  logic [IW-1:0]        tag_q,       tag_d;
  logic [ADDR_SIZE-1:0] hold_addr_q, hold_addr_d;
  logic [NREQ-1:0]      rd_valid_q,  rd_valid_d;
  logic [DATA_SIZE-1:0] rd_data_q,   rd_data_d;

  assign arb_en_s = en & rst_n;

  rr_arbiter #(.N(NREQ), .IDX_W(IW)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (arb_en_s),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_win_s),
    .gnt_any (wr_any_s)
  );

  rr_arbiter #(.N(NREQ), .IDX_W(IW)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (arb_en_s),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_win_s),
    .gnt_any (rd_any_s)
  );

  // A new grant takes the address bus even while the previous read is returning.
  always_comb begin
    phase_s = rd_any_s ? RD_ISSUE : pipe_q;
    if (!rst_n) begin
      phase_s = RD_IDLE;
    end else begin
      phase_s = phase_s;
    end
  end

  always_comb begin
    ram_we         = wr_any_s;
    ram_re         = (phase_s != RD_IDLE);
    ram_oe         = ram_re;
    ram_cs         = ram_we | ram_re;
    ram_wr_address = wr_any_s ? wr_addr[wr_win_s*ADDR_SIZE +: ADDR_SIZE] : '0;
    ram_data_in    = wr_any_s ? wr_data[wr_win_s*DATA_SIZE +: DATA_SIZE] : '0;
    case (phase_s)
      RD_ISSUE:  ram_rd_address = rd_addr[rd_win_s*ADDR_SIZE +: ADDR_SIZE];
      RD_RETURN: ram_rd_address = hold_addr_q;
      default:   ram_rd_address = '0;
    endcase
  end

  always_comb begin
    pipe_d      = rd_any_s ? RD_RETURN : RD_IDLE;
    tag_d       = rd_any_s ? rd_win_s : tag_q;
    hold_addr_d = rd_any_s ? rd_addr[rd_win_s*ADDR_SIZE +: ADDR_SIZE] : hold_addr_q;
    if (pipe_q == RD_RETURN) begin
      rd_valid_d = NREQ'(1) << tag_q;
      rd_data_d  = ram_data_out;
    end else begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q      <= RD_IDLE;
      tag_q       <= '0;
      hold_addr_q <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      pipe_q      <= pipe_d;
      tag_q       <= tag_d;
      hold_addr_q <= hold_addr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
